// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin block-transfer arbiter between icache/dcache and datamem
//
// Purpose:
//   Owns the single block-wide data memory port. The instruction cache issues refill
//   reads only; the data cache issues refill reads and dirty-block write-backs. One
//   block transfer is sequenced at a time over a req/ack handshake to memory, and the
//   read block is returned on a registered bus shared by both caches.
//
//   Sequence per transfer: IDLE (arbitrate) -> BUSY (mem_req held) -> RESP (ack pulse).
//   Ties are broken round robin against the last grant; after reset the first tie
//   goes to the icache.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_ic_req/i_ic_addr    icache refill request, held until o_ic_ack
//   o_ic_ack              1-cycle pulse, o_rdata valid for icache
//   i_dc_req/i_dc_we/
//   i_dc_addr/i_dc_wdata  dcache request (we=1 write-back, we=0 refill), held until o_dc_ack
//   o_dc_ack              1-cycle pulse, transfer complete (o_rdata valid on reads)
//   o_rdata               registered read block shared by both caches
//   o_mem_req/o_mem_we/
//   o_mem_addr/o_mem_wdata  memory request, fields stable while o_mem_req
//   i_mem_ack/i_mem_rdata   memory completion pulse and read block
//
// Configuration:
//   MEMARB_PERF_EN  adds saturating counters o_perf_ic_grants, o_perf_dc_grants and
//                   o_perf_wait_cycles (CNT_W bits each). Undefined: ports absent.

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int BLOCK_W  = 128,
    parameter int OFFSET_W = 7,
    parameter int CNT_W    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic               i_ic_req,
    input  logic [ADDR_W-1:0]  i_ic_addr,
    output logic               o_ic_ack,

    input  logic               i_dc_req,
    input  logic               i_dc_we,
    input  logic [ADDR_W-1:0]  i_dc_addr,
    input  logic [BLOCK_W-1:0] i_dc_wdata,
    output logic               o_dc_ack,

    output logic [BLOCK_W-1:0] o_rdata,

    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [BLOCK_W-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [BLOCK_W-1:0] i_mem_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [CNT_W-1:0]   o_perf_ic_grants,
    output logic [CNT_W-1:0]   o_perf_dc_grants,
    output logic [CNT_W-1:0]   o_perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Owner encoding: 0 = icache, 1 = dcache.
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    if (OFFSET_W < 1 || OFFSET_W >= ADDR_W || CNT_W < 1) begin : g_param_check
        $error("mem_arbiter: illegal parameter combination");
    end

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_owner;
    logic                 r_last_grant;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [BLOCK_W-1:0]   r_wdata;
    logic [BLOCK_W-1:0]   r_rdata;

    logic                 w_grant;
    logic                 w_grant_dc;
    logic [ADDR_W-1:0]    w_sel_addr;

    // Next-state, arbitration and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_dc   = 1'b0;
        o_mem_req    = 1'b0;
        o_ic_ack     = 1'b0;
        o_dc_ack     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_ic_req && i_dc_req) begin
                    // Both pending: give it to whoever did not win last time.
                    w_grant    = 1'b1;
                    w_grant_dc = (r_last_grant == OWN_IC);
                end else if (i_ic_req) begin
                    w_grant    = 1'b1;
                    w_grant_dc = 1'b0;
                end else if (i_dc_req) begin
                    w_grant    = 1'b1;
                    w_grant_dc = 1'b1;
                end
                if (w_grant) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                o_ic_ack     = (r_owner == OWN_IC);
                o_dc_ack     = (r_owner == OWN_DC);
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Block address of the winning requester, offset bits forced to zero.
    always_comb begin
        w_sel_addr = w_grant_dc ? i_dc_addr : i_ic_addr;
        w_sel_addr = {w_sel_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transfer fields are captured once at grant so they stay stable for the
    // whole time mem_req is high, regardless of what the requester does.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner      <= OWN_IC;
            r_last_grant <= OWN_DC;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_owner      <= w_grant_dc;
            r_last_grant <= w_grant_dc;
            r_we         <= w_grant_dc & i_dc_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_grant_dc ? i_dc_wdata : '0;
        end
    end

    // Read data is only captured for reads; a write-back leaves the last block visible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (r_state == S_BUSY && i_mem_ack && !r_we) begin
            r_rdata <= i_mem_rdata;
        end
    end

    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_rdata     = r_rdata;

`ifdef MEMARB_PERF_EN
    logic [CNT_W-1:0] r_perf_ic_grants;
    logic [CNT_W-1:0] r_perf_dc_grants;
    logic [CNT_W-1:0] r_perf_wait_cycles;
    logic             w_ic_served;
    logic             w_dc_served;
    logic             w_waiting;

    // A requester counts as served while its transfer is in BUSY or RESP.
    assign w_ic_served = (r_state != S_IDLE) && (r_owner == OWN_IC);
    assign w_dc_served = (r_state != S_IDLE) && (r_owner == OWN_DC);
    assign w_waiting   = (i_ic_req && !w_ic_served) || (i_dc_req && !w_dc_served);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_ic_grants   <= '0;
            r_perf_dc_grants   <= '0;
            r_perf_wait_cycles <= '0;
        end else begin
            if (w_grant && !w_grant_dc && r_perf_ic_grants != '1) begin
                r_perf_ic_grants <= r_perf_ic_grants + 1'b1;
            end
            if (w_grant && w_grant_dc && r_perf_dc_grants != '1) begin
                r_perf_dc_grants <= r_perf_dc_grants + 1'b1;
            end
            if (w_waiting && r_perf_wait_cycles != '1) begin
                r_perf_wait_cycles <= r_perf_wait_cycles + 1'b1;
            end
        end
    end

    assign o_perf_ic_grants   = r_perf_ic_grants;
    assign o_perf_dc_grants   = r_perf_dc_grants;
    assign o_perf_wait_cycles = r_perf_wait_cycles;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_ic_req = 1'b0;
    logic [31:0]  i_ic_addr = '0;
    logic         o_ic_ack;
    logic         i_dc_req = 1'b0;
    logic         i_dc_we = 1'b0;
    logic [31:0]  i_dc_addr = '0;
    logic [127:0] i_dc_wdata = '0;
    logic         o_dc_ack;
    logic [127:0] o_rdata;
    logic         o_mem_req;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [127:0] o_mem_wdata;
    logic         i_mem_ack = 1'b0;
    logic [127:0] i_mem_rdata = '0;
`ifdef MEMARB_PERF_EN
    logic [31:0]  o_perf_ic_grants;
    logic [31:0]  o_perf_dc_grants;
    logic [31:0]  o_perf_wait_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] RD_A = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    localparam logic [127:0] WD_A = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
    localparam logic [127:0] RD_B = 128'hCAFEF00D_11112222_33334444_55556666;

    mem_arbiter dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ic_req    (i_ic_req),
        .i_ic_addr   (i_ic_addr),
        .o_ic_ack    (o_ic_ack),
        .i_dc_req    (i_dc_req),
        .i_dc_we     (i_dc_we),
        .i_dc_addr   (i_dc_addr),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_ack    (o_dc_ack),
        .o_rdata     (o_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
`ifdef MEMARB_PERF_EN
        ,
        .o_perf_ic_grants   (o_perf_ic_grants),
        .o_perf_dc_grants   (o_perf_dc_grants),
        .o_perf_wait_cycles (o_perf_wait_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Plays the memory side of one transfer: waits (bounded) for mem_req, checks the
    // request fields, acks lat cycles after the first mem_req cycle, then checks the
    // response cycle. Returns with the bench sitting in the RESP cycle.
    task automatic run_xfer(input string tag, input int lat, input logic [127:0] rd,
                            input logic [31:0] exp_addr, input logic exp_we,
                            input logic [127:0] exp_wdata, input logic exp_dc,
                            output int waited);
        waited = 0;
        while (!o_mem_req && waited < 20) begin
            step();
            waited++;
        end
        check({tag, ":mem_req"}, o_mem_req, 1'b1);
        check({tag, ":mem_addr"}, o_mem_addr, exp_addr);
        check({tag, ":mem_we"}, o_mem_we, exp_we);
        if (exp_we) check({tag, ":mem_wdata"}, o_mem_wdata, exp_wdata);
        for (int i = 0; i < lat; i++) step();
        i_mem_ack   = 1'b1;
        i_mem_rdata = rd;
        step();
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        check({tag, ":mem_req_drop"}, o_mem_req, 1'b0);
        check({tag, ":ic_ack"}, o_ic_ack, !exp_dc);
        check({tag, ":dc_ack"}, o_dc_ack, exp_dc);
    endtask

    initial begin
        int waited;
        int acks_ic;
        int acks_dc;
        int busy_cnt;

        // Reset state
        step();
        check("rst:mem_req", o_mem_req, 1'b0);
        check("rst:mem_we", o_mem_we, 1'b0);
        check("rst:mem_addr", o_mem_addr, 32'h0);
        check("rst:rdata", o_rdata, 128'h0);
        check("rst:acks", {o_ic_ack, o_dc_ack}, 2'b00);
        i_rst = 1'b0;
        step();

        // 1: icache refill, offset bits cleared
        i_ic_req  = 1'b1;
        i_ic_addr = 32'h0000_01A4;
        run_xfer("t1", 2, RD_A, 32'h0000_0180, 1'b0, '0, 1'b0, waited);
        check("t1:latency", waited, 1);
        i_ic_req = 1'b0;
        step();
        check("t1:rdata", o_rdata, RD_A);
        check("t1:idle_acks", {o_ic_ack, o_dc_ack}, 2'b00);

        // 2: dcache write-back leaves rdata alone
        i_dc_req   = 1'b1;
        i_dc_we    = 1'b1;
        i_dc_addr  = 32'h0000_0280;
        i_dc_wdata = WD_A;
        run_xfer("t2", 3, RD_B, 32'h0000_0280, 1'b1, WD_A, 1'b1, waited);
        i_dc_req = 1'b0;
        i_dc_we  = 1'b0;
        step();
        check("t2:rdata_kept", o_rdata, RD_A);

        // 3: simultaneous requests alternate IC, DC, IC, DC with one idle cycle between
        i_rst = 1'b1;
        step();
        i_rst     = 1'b0;
        i_ic_req  = 1'b1;
        i_ic_addr = 32'h0000_1000;
        i_dc_req  = 1'b1;
        i_dc_addr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            logic is_dc;
            is_dc = k[0];
            run_xfer($sformatf("t3_%0d", k), 2, RD_B,
                     is_dc ? 32'h0000_2000 : 32'h0000_1000, 1'b0, '0, is_dc, waited);
            check($sformatf("t3_%0d:gap", k), waited, (k == 0) ? 1 : 2);
            if (k == 3) begin
                i_ic_req = 1'b0;
                i_dc_req = 1'b0;
            end
        end
        step();
`ifdef MEMARB_PERF_EN
        // Wait cycles: 1 (first IDLE) + 3 x (4 transfer cycles + 1 gap) + 3 (last RESP has no reqs)
        check("t6:perf_ic", o_perf_ic_grants, 32'd2);
        check("t6:perf_dc", o_perf_dc_grants, 32'd2);
        check("t6:perf_wait", o_perf_wait_cycles, 32'd19);
`endif

        // 4: reset while BUSY drops the transfer asynchronously
        i_ic_req  = 1'b1;
        i_ic_addr = 32'h0000_3000;
        step();
        check("t4:busy", o_mem_req, 1'b1);
        step();
        i_rst = 1'b1;
        #1;
        check("t4:async_mem_req", o_mem_req, 1'b0);
        check("t4:async_addr", o_mem_addr, 32'h0);
        i_ic_req = 1'b0;
        step();
        check("t4:no_ack", {o_ic_ack, o_dc_ack}, 2'b00);
        i_rst = 1'b0;
        step();
        i_ic_req  = 1'b1;
        i_ic_addr = 32'h0000_44C0;
        run_xfer("t4b", 1, RD_B, 32'h0000_4480, 1'b0, '0, 1'b0, waited);
        i_ic_req = 1'b0;
        step();
        check("t4b:rdata", o_rdata, RD_B);

        // 5: stray mem_ack in IDLE is ignored
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        check("t5:stray_req", o_mem_req, 1'b0);
        check("t5:stray_acks", {o_ic_ack, o_dc_ack}, 2'b00);
        step();
        check("t5:stray_acks2", {o_ic_ack, o_dc_ack}, 2'b00);

        // 5b: dc_req held 40 cycles, memory acks after 38 busy cycles -> one dc_ack
        acks_ic  = 0;
        acks_dc  = 0;
        busy_cnt = 0;
        i_dc_req  = 1'b1;
        i_dc_we   = 1'b0;
        i_dc_addr = 32'h0000_5000;
        for (int c = 0; c < 40; c++) begin
            step();
            if (o_ic_ack) acks_ic++;
            if (o_dc_ack) begin
                acks_dc++;
                i_dc_req = 1'b0;
            end
            if (o_mem_req) busy_cnt++;
            i_mem_ack = o_mem_req && (busy_cnt == 38);
        end
        i_mem_ack = 1'b0;
        i_dc_req  = 1'b0;
        check("t5:dc_acks", acks_dc, 1);
        check("t5:ic_acks", acks_ic, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
